// File: rtl/apb4_mem_slave.sv
// APB4 scratchpad memory slave with byte strobes, wait states and error/violation reporting.
// Optional build macro APB_MEM_WPROT_EN makes the lowest WPROT_WORDS words read-only.
module apb4_mem_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 16,
  parameter int unsigned PADDR_W     = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned WPROT_WORDS = 4
) (
  input  logic                    pclk_i,
  input  logic                    preset_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [PADDR_W-1:0]      paddr_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [7:0]              viol_cnt_o
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned OFF = $clog2(NB);
  localparam int unsigned IW  = PADDR_W - OFF;
  localparam int unsigned MIW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef APB_MEM_WPROT_EN
  localparam bit WprotEn = 1'b1;
`else
  localparam bit WprotEn = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                  state_q;
  logic [3:0]              wcnt_q;
  logic [PADDR_W-1:0]      addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           strb_q;
  logic [7:0]              viol_q;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [IW-1:0]  idx;
  logic [31:0]    idx_ext;
  logic [MIW-1:0] mem_idx;
  logic           misal_err;
  logic           range_err;
  logic           wprot_err;
  logic           err;
  logic           ready;
  logic           viol;

  assign idx     = addr_q[PADDR_W-1:OFF];
  assign idx_ext = 32'(idx);
  assign mem_idx = MIW'(idx_ext);

  if (OFF > 0) begin : g_align
    assign misal_err = |addr_q[OFF-1:0];
  end else begin : g_noalign
    assign misal_err = 1'b0;
  end

  assign range_err = (idx_ext >= MEM_DEPTH);
  assign wprot_err = WprotEn && write_q && (idx_ext < WPROT_WORDS);
  assign err       = range_err | misal_err | wprot_err;

  assign ready = (state_q == StAccess) && (wcnt_q == 4'd0);

  // Setup-less enable in idle, or a dropped strobe before completion.
  assign viol = ((state_q == StIdle) && psel_i && penable_i) ||
                ((state_q == StAccess) && !(psel_i && penable_i));

  assign pready_o   = ready;
  assign pslverr_o  = ready & err;
  assign prdata_o   = (ready && !write_q && !err) ? mem[mem_idx] : '0;
  assign viol_cnt_o = viol_q;

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q <= StIdle;
      wcnt_q  <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      viol_q  <= 8'd0;
      mem     <= '{default: '0};
    end else begin
      if (viol && (viol_q != 8'hFF)) begin
        viol_q <= viol_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (psel_i && !penable_i) begin
            addr_q  <= paddr_i;
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
            strb_q  <= pstrb_i;
            wcnt_q  <= 4'(WAIT_STATES);
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (!(psel_i && penable_i)) begin
            state_q <= StIdle;
          end else if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end else begin
            if (write_q && !err) begin
              for (int unsigned b = 0; b < NB; b++) begin
                if (strb_q[b]) mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
              end
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: three instances (0, 2 and 3 wait states) against a word-array model.
// Honours APB_MEM_WPROT_EN when the build defines it.
module tb_apb4_mem_slave;

`ifdef APB_MEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  logic [7:0]  viol_cnt [3];

  logic [31:0] mdl [3][16];
  int          vmdl [3];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb4_mem_slave #(
      .DATA_WIDTH (32),
      .MEM_DEPTH  (16),
      .PADDR_W    (12),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 2 : 3),
      .WPROT_WORDS(4)
    ) u_dut (
      .pclk_i    (pclk),
      .preset_i  (preset),
      .psel_i    (psel[g]),
      .penable_i (penable),
      .pwrite_i  (pwrite),
      .paddr_i   (paddr),
      .pwdata_i  (pwdata),
      .pstrb_i   (pstrb),
      .prdata_o  (prdata[g]),
      .pready_o  (pready[g]),
      .pslverr_o (pslverr[g]),
      .viol_cnt_o(viol_cnt[g])
    );
  end

  function automatic int ws(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      vmdl[d] = 0;
      for (int i = 0; i < 16; i++) mdl[d][i] = 32'h0;
    end
  endtask

  task automatic idle();
    psel = 3'b000;
    penable = 1'b0;
  endtask

  task automatic note_viol(input int d);
    if (vmdl[d] < 255) vmdl[d]++;
  endtask

  // One complete transfer; leaves psel high so a setup may follow directly.
  task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output int done, output logic [31:0] rd);
    int          n;
    int          idx;
    bit          err;
    logic [31:0] er;
    idx = int'(a[11:2]);
    err = (idx >= 16) || (a[1:0] != 2'b00) || (WPROT && wr && idx < 4);
    er  = 32'h0;
    if (!wr && !err) er = mdl[d][idx];
    psel = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = wd;
    pstrb = st;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr = 12'($urandom);
    pwdata = $urandom;
    if (!wr) pstrb = 4'($urandom);
    n = 1;
    while (pready[d] !== 1'b1 && n < 40) begin
      chk("wait_outputs_zero", {pslverr[d], prdata[d][30:0]}, 32'h0);
      @(posedge pclk); #1;
      n++;
    end
    chk("latency", n, ws(d) + 1);
    chk("pslverr", {31'h0, pslverr[d]}, {31'h0, err});
    chk("prdata", prdata[d], er);
    rd = prdata[d];
    done = cyc;
    @(posedge pclk); #1;
    if (wr && !err)
      for (int b = 0; b < 4; b++) if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk(tag, {pready[d], pslverr[d], prdata[d][29:0]}, 32'h0);
      chk("viol_cnt", {24'h0, viol_cnt[d]}, 32'(vmdl[d]));
    end
  endtask

  initial begin
    int          done;
    int          prev;
    logic [31:0] rd;

    preset = 1'b1;
    idle();
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    pstrb = '0;
    clear_model();
    @(posedge pclk); @(posedge pclk); #1;
    check_idle_outputs("reset_outputs");
    chk("reset_prdata_msb", {31'h0, prdata[0][31]}, 32'h0);
    preset = 1'b0;

    // Basic write then read, zero wait states.
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, done, rd);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, done, rd);
    chk("basic_read", rd, 32'hDEADBEEF);
    idle();

    // Byte-strobe merge.
    xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF, done, rd);
    xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, done, rd);
    xfer(0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'b0000, done, rd);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, done, rd);
    chk("strobe_merge", rd, 32'h11BB33DD);
    idle();

    // Out-of-range and misaligned accesses.
    xfer(0, 1'b0, 12'h040, 32'h0, 4'hF, done, rd);
    xfer(0, 1'b1, 12'h012, 32'h55555555, 4'hF, done, rd);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, done, rd);
    chk("misaligned_no_write", rd, 32'hDEADBEEF);
    idle();

    // Write-protected region (expected behaviour follows the build macro).
    xfer(0, 1'b1, 12'h004, 32'h0000005A, 4'hF, done, rd);
    xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, done, rd);
    chk("wprot_word", rd, WPROT ? 32'h0 : 32'h5A);
    xfer(0, 1'b1, 12'h010, 32'h0BADF00D, 4'hF, done, rd);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, done, rd);
    idle();

    // Three wait states: read latency and back-to-back write spacing.
    @(posedge pclk); #1;
    xfer(2, 1'b0, 12'h008, 32'h0, 4'h0, done, rd);
    xfer(2, 1'b1, 12'h018, 32'h01020304, 4'hF, prev, rd);
    for (int i = 0; i < 3; i++) begin
      xfer(2, 1'b1, 12'(12'h01C + 4 * i), $urandom, 4'hF, done, rd);
      chk("b2b_spacing", done - prev, 5);
      prev = done;
    end
    idle();

    // Dropped select mid-wait, then enable without setup.
    @(posedge pclk); #1;
    psel[1] = 1'b1; pwrite = 1'b1; paddr = 12'h02C; pwdata = 32'hCAFEBABE; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    idle();
    @(posedge pclk); #1;
    note_viol(1);
    psel[1] = 1'b1; penable = 1'b1;
    @(posedge pclk); #1;
    note_viol(1);
    idle();
    chk("viol_two", {24'h0, viol_cnt[1]}, 32'd2);
    xfer(1, 1'b0, 12'h02C, 32'h0, 4'h0, done, rd);
    chk("aborted_no_write", rd, 32'h0);
    idle();
    psel[1] = 1'b1;
    penable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge pclk);
      note_viol(1);
    end
    #1;
    idle();
    chk("viol_saturate", {24'h0, viol_cnt[1]}, 32'd255);

    // Randomized traffic on all three instances.
    for (int i = 0; i < 60; i++) begin
      int          d;
      logic [11:0] a;
      d = $urandom_range(0, 2);
      a = {$urandom_range(0, 19) & 10'h3FF, 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom);
      xfer(d, 1'($urandom), a, $urandom, 4'($urandom), done, rd);
      if ($urandom_range(0, 1) == 1) begin
        idle();
        @(posedge pclk); #1;
      end
    end
    idle();
    @(posedge pclk); #1;
    check_idle_outputs("idle_outputs");

    // Reset in the middle of a write.
    psel[0] = 1'b1; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    idle();
    clear_model();
    check_idle_outputs("midreset_outputs");
    xfer(0, 1'b0, 12'h030, 32'h0, 4'h0, done, rd);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, done, rd);
    chk("reset_cleared", rd, 32'h0);
    xfer(2, 1'b0, 12'h018, 32'h0, 4'h0, done, rd);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb4_mem_slave.md
Name: apb4_mem_slave

Overview:
Parametrised APB4 memory-mapped slave and next generation of the team's 8-bit/16-deep APB slave memory. Adds configurable data width and depth, byte strobes and programmable wait states. Adds address/alignment error responses and a saturating protocol-violation counter. Sits behind an APB interconnect as a scratchpad or register-file target.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be 8, 16, 32 or 64.
MEM_DEPTH, 16, number of DATA_WIDTH words.
PADDR_W, 12, byte-address width of paddr_i.
WAIT_STATES, 0, wait cycles inserted per access, from 0 to 15.
WPROT_WORDS, 4, number of write-protected words at index 0 upward; used only with the optional feature.

Ports:
pclk_i  in  1  clock; all logic on the rising edge
preset_i  in  1  synchronous, active-high reset
psel_i  in  1  slave select
penable_i  in  1  access-phase strobe
pwrite_i  in  1  1 = write, 0 = read
paddr_i  in  PADDR_W  byte address
pwdata_i  in  DATA_WIDTH  write data
pstrb_i  in  DATA_WIDTH/8  write byte strobes
prdata_o  out  DATA_WIDTH  read data
pready_o  out  1  transfer complete
pslverr_o  out  1  error response
viol_cnt_o  out  8  saturating protocol-violation count

Behaviour:
- Reset: preset_i high at a rising edge.
  - Outputs: prdata_o=0, pready_o=0, pslverr_o=0, viol_cnt_o=0.
  - FSM goes to IDLE and all memory words are cleared to 0.
  - Reset mid-transfer aborts the transfer with no memory write.
- Definitions:
  - OFF = log2(DATA_WIDTH/8).
  - Word index = paddr_i[PADDR_W-1:OFF].
- FSM state IDLE:
  - psel_i=1 and penable_i=0 sampled: capture addr, write, wdata and strb; load wcnt=WAIT_STATES; go to ACCESS.
  - psel_i=1 and penable_i=1 sampled: violation; stay in IDLE.
- FSM state ACCESS:
  - pready_o = (wcnt==0), decoded from registered state.
  - While wcnt!=0: wcnt decrements each cycle.
  - psel_i=0 or penable_i=0 sampled before completion: violation; abort to IDLE with no write.
  - Completion edge (psel_i, penable_i and pready_o all 1): write commits; go to IDLE.
- Latency and back-to-back:
  - Completion occurs in access cycle WAIT_STATES+1.
  - A setup phase in the cycle after completion is accepted; a transfer every 2+WAIT_STATES cycles.
- Error decode (evaluated on captured addr):
  - Word index >= MEM_DEPTH.
  - paddr low OFF bits nonzero.
  - Write-protect hit (optional feature only).
- Error response and data rules:
  - pslverr_o=1 only while pready_o=1; otherwise 0.
  - Errored write leaves memory unchanged. Errored read returns prdata_o=0.
  - Write updates only byte lanes whose pstrb bit is 1. pstrb=0 is an OKAY no-op.
  - pstrb_i is ignored on reads.
  - prdata_o carries the word only while pready_o=1 on a read; otherwise 0.
- Violation counter: viol_cnt_o increments by 1 per violation and saturates at 255. It is cleared only by reset.
- Captured fields stay stable through the wait states; bus changes to paddr/pwdata during ACCESS are ignored.

Optional Feature:
APB_MEM_WPROT_EN:
- Defined: word indices 0 to WPROT_WORDS-1 are read-only.
  - A write to them completes with pslverr_o=1 and memory unchanged.
  - Reads to them are normal.
- Undefined: no write protection; WPROT_WORDS is unused.

Test Plan:
1. Reset, then DATA_WIDTH=32 and WAIT_STATES=0: write 0xDEADBEEF to 0x010, read 0x010 -> pready_o high in first access cycle, prdata_o=0xDEADBEEF, pslverr_o=0.
2. Word 0x020 preloaded with 0x11223344, then write 0xAABBCCDD with pstrb=4'b0101 to 0x020 -> read returns 0x11BB33DD.
3. WAIT_STATES=3: single read -> pready_o low for 3 access cycles, high in the 4th; back-to-back writes complete every 5 cycles.
4. Read 0x040 (index 16) and write 0x012 (misaligned) -> pslverr_o=1 with pready_o, prdata_o=0, memory unchanged.
5. psel_i dropped mid-wait with WAIT_STATES=2, then penable_i=1 without setup -> no write, viol_cnt_o=2; 300 violations -> viol_cnt_o=255.
6. With APB_MEM_WPROT_EN and WPROT_WORDS=4: write 0x5A to 0x004 -> pslverr_o=1 and word stays 0; write to 0x010 succeeds. Assert preset_i mid-transfer -> all outputs 0, memory cleared.
